// File: rtl/yari_stage_decode_pkg.sv
// Shared constants for the YARI decode stage: opcode, funct and REGIMM encodings,
// CP0 bank offset and the 6-bit register-index type.
package yari_stage_decode_pkg;

    localparam int unsigned RegIdxW = 6;
    localparam int unsigned NumRegs = 1 << RegIdxW;

    typedef logic [RegIdxW-1:0] reg_idx_t;

    // CP0 registers live in the upper half of the register index space.
    localparam reg_idx_t Cp0Base = 6'd32;
    localparam reg_idx_t RegRa   = 6'd31;

    // Primary opcodes
    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpRegimm  = 6'h01;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpBne     = 6'h05;
    localparam logic [5:0] OpBlez    = 6'h06;
    localparam logic [5:0] OpBgtz    = 6'h07;
    localparam logic [5:0] OpAddi    = 6'h08;
    localparam logic [5:0] OpAddiu   = 6'h09;
    localparam logic [5:0] OpSlti    = 6'h0a;
    localparam logic [5:0] OpSltiu   = 6'h0b;
    localparam logic [5:0] OpAndi    = 6'h0c;
    localparam logic [5:0] OpOri     = 6'h0d;
    localparam logic [5:0] OpXori    = 6'h0e;
    localparam logic [5:0] OpLui     = 6'h0f;
    localparam logic [5:0] OpCop0    = 6'h10;
    localparam logic [5:0] OpLb      = 6'h20;
    localparam logic [5:0] OpLh      = 6'h21;
    localparam logic [5:0] OpLwl     = 6'h22;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpLbu     = 6'h24;
    localparam logic [5:0] OpLhu     = 6'h25;
    localparam logic [5:0] OpLwr     = 6'h26;

    // SPECIAL funct codes that change control flow
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnJalr = 6'h09;

    // REGIMM rt codes
    localparam logic [4:0] RiBltz   = 5'h00;
    localparam logic [4:0] RiBgez   = 5'h01;
    localparam logic [4:0] RiBltzal = 5'h10;
    localparam logic [4:0] RiBgezal = 5'h11;

    // COP0 rs sub-opcodes
    localparam logic [4:0] Cop0Mf = 5'h00;
    localparam logic [4:0] Cop0Mt = 5'h04;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/yari_stage_decode_if.sv
// Bundle of the I/X/M-facing inputs and X-facing outputs of the decode stage.
// master drives the pipeline inputs; slave is the decode stage itself.
interface yari_stage_decode_if;
    logic        i_valid;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_npc;
    logic        x_valid;
    logic [5:0]  x_wbr;
    logic [31:0] x_res;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [5:0]  m_wbr;
    logic [31:0] m_res;
    logic        flush_D;

    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_npc;
    logic [5:0]  d_opcode;
    logic [5:0]  d_fn;
    logic [4:0]  d_rd;
    logic [4:0]  d_sa;
    logic [5:0]  d_rs;
    logic [5:0]  d_rt;
    logic [5:0]  d_wbr;
    logic [31:0] d_target;
    logic        d_has_delay_slot;
    logic [31:0] d_op1_val;
    logic [31:0] d_op2_val;
    logic [31:0] d_rt_val;
    logic [31:0] d_simm;
    logic        d_restart;
    logic [31:0] d_restart_pc;
    logic        d_flush_X;
    logic [31:0] perf_delay_slot_bubble;
    logic [47:0] perf_retired_inst;

    modport master (
        output i_valid, i_instr, i_pc, i_npc, x_valid, x_wbr, x_res,
               m_valid, m_pc, m_wbr, m_res, flush_D,
        input  d_valid, d_instr, d_pc, d_npc, d_opcode, d_fn, d_rd, d_sa, d_rs, d_rt,
               d_wbr, d_target, d_has_delay_slot, d_op1_val, d_op2_val, d_rt_val, d_simm,
               d_restart, d_restart_pc, d_flush_X, perf_delay_slot_bubble, perf_retired_inst
    );

    modport slave (
        input  i_valid, i_instr, i_pc, i_npc, x_valid, x_wbr, x_res,
               m_valid, m_pc, m_wbr, m_res, flush_D,
        output d_valid, d_instr, d_pc, d_npc, d_opcode, d_fn, d_rd, d_sa, d_rs, d_rt,
               d_wbr, d_target, d_has_delay_slot, d_op1_val, d_op2_val, d_rt_val, d_simm,
               d_restart, d_restart_pc, d_flush_X, perf_delay_slot_bubble, perf_retired_inst
    );
endinterface

// File: rtl/yari_regfile.sv
// 64x32 register file: GPRs 0..31, CP0 32..63. Two async read ports, one write port.
// Index 0 reads as zero and is never written. Contents are not reset.
module yari_regfile
    import yari_stage_decode_pkg::*;
(
    input  logic        clk_i,
    input  logic        we_i,
    input  reg_idx_t    waddr_i,
    input  logic [31:0] wdata_i,
    input  reg_idx_t    raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  reg_idx_t    raddr_b_i,
    output logic [31:0] rdata_b_o
);
    logic [31:0] mem_q [NumRegs];

    // Write port; writes to r0 are dropped.
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? 32'h0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? 32'h0 : mem_q[raddr_b_i];
endmodule

// File: rtl/yari_stage_decode.sv
// YARI MIPS-I decode stage: latches the fetched instruction, decodes fields, reads
// operands with X/M bypass and raises a restart when a branch loses its delay slot.
// Optional macro YARI_DECODE_PERF_EN enables the performance counters.
module yari_stage_decode
    import yari_stage_decode_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input logic                clock,
    input logic                rst,
    yari_stage_decode_if.slave dec
);
    logic [5:0]  opcode, fn;
    logic [4:0]  rs5, rt5, rd5;
    logic [15:0] imm;
    logic        is_itype, is_jtype;

    assign opcode = dec.i_instr[31:26];
    assign rs5    = dec.i_instr[25:21];
    assign rt5    = dec.i_instr[20:16];
    assign rd5    = dec.i_instr[15:11];
    assign fn     = dec.i_instr[5:0];
    assign imm    = dec.i_instr[15:0];

    assign is_jtype = (opcode == OpJ) || (opcode == OpJal);
    // Everything except SPECIAL, J/JAL and the coprocessor opcodes carries imm16.
    assign is_itype = !((opcode == OpSpecial) || is_jtype || (opcode[5:2] == 4'b0100));

    reg_idx_t    src_rs_d, src_rt_d, wbr_d;
    logic        has_ds_d;
    logic [31:0] simm_d, target_d, op1_d, op2_d, rt_val_d, rf_rs, rf_rt;

    // Decode source/destination specifiers and whether a delay slot follows.
    always_comb begin
        src_rs_d = {1'b0, rs5};
        src_rt_d = {1'b0, rt5};
        wbr_d    = '0;
        has_ds_d = 1'b0;
        case (opcode)
            OpSpecial: begin
                has_ds_d = (fn == FnJr) || (fn == FnJalr);
                if (fn != FnJr) wbr_d = {1'b0, rd5};
            end
            OpRegimm: begin
                has_ds_d = (rt5 == RiBltz) || (rt5 == RiBgez) ||
                           (rt5 == RiBltzal) || (rt5 == RiBgezal);
                if ((rt5 == RiBltzal) || (rt5 == RiBgezal)) wbr_d = RegRa;
            end
            OpJ: has_ds_d = 1'b1;
            OpJal: begin
                has_ds_d = 1'b1;
                wbr_d    = RegRa;
            end
            OpBeq, OpBne, OpBlez, OpBgtz: has_ds_d = 1'b1;
            OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui,
            OpLb, OpLh, OpLwl, OpLw, OpLbu, OpLhu, OpLwr: wbr_d = {1'b0, rt5};
            OpCop0: begin
                if (rs5 == Cop0Mf) begin
                    src_rs_d = Cp0Base | {1'b0, rd5};
                    wbr_d    = {1'b0, rt5};
                end else if (rs5 == Cop0Mt) begin
                    wbr_d = Cp0Base | {1'b0, rd5};
                end
            end
            default: ;
        endcase
    end

    yari_regfile u_regfile (
        .clk_i    (clock),
        .we_i     (dec.m_valid),
        .waddr_i  (dec.m_wbr),
        .wdata_i  (dec.m_res),
        .raddr_a_i(src_rs_d),
        .rdata_a_o(rf_rs),
        .raddr_b_i(src_rt_d),
        .rdata_b_o(rf_rt)
    );

    // X result beats M result beats register file; index 0 never forwards.
    function automatic logic [31:0] fwd(input reg_idx_t src, input logic xv,
                                        input reg_idx_t xw, input logic [31:0] xr,
                                        input logic mv, input reg_idx_t mw,
                                        input logic [31:0] mr, input logic [31:0] rf);
        if (src == '0) return 32'h0;
        if (xv && (xw == src)) return xr;
        if (mv && (mw == src)) return mr;
        return rf;
    endfunction

    assign simm_d   = sext16(imm);
    assign op1_d    = fwd(src_rs_d, dec.x_valid, dec.x_wbr, dec.x_res,
                          dec.m_valid, dec.m_wbr, dec.m_res, rf_rs);
    assign rt_val_d = fwd(src_rt_d, dec.x_valid, dec.x_wbr, dec.x_res,
                          dec.m_valid, dec.m_wbr, dec.m_res, rf_rt);
    assign target_d = is_jtype ? {dec.i_npc[31:28], dec.i_instr[25:0], 2'b00}
                               : dec.i_npc + {simm_d[29:0], 2'b00};

    // Second operand: immediate forms for I-type, otherwise the rt value.
    always_comb begin
        op2_d = rt_val_d;
        if ((opcode == OpAndi) || (opcode == OpOri) || (opcode == OpXori)) begin
            op2_d = {16'h0, imm};
        end else if (opcode == OpLui) begin
            op2_d = {imm, 16'h0};
        end else if (is_itype) begin
            op2_d = simm_d;
        end
    end

    logic        valid_q, has_ds_q;
    logic [31:0] instr_q, pc_q, npc_q, target_q, op1_q, op2_q, rt_val_q, simm_q;
    reg_idx_t    rs_q, rt_q, wbr_q;

    // Pipeline register: no stall, everything advances every cycle.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_q     <= RESET_PC;
            npc_q    <= RESET_PC;
            rs_q     <= '0;
            rt_q     <= '0;
            wbr_q    <= '0;
            target_q <= '0;
            has_ds_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            rt_val_q <= '0;
            simm_q   <= '0;
        end else begin
            valid_q  <= dec.i_valid;
            instr_q  <= dec.i_instr;
            pc_q     <= dec.i_pc;
            npc_q    <= dec.i_npc;
            rs_q     <= src_rs_d;
            rt_q     <= src_rt_d;
            wbr_q    <= wbr_d;
            target_q <= target_d;
            has_ds_q <= has_ds_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rt_val_q <= rt_val_d;
            simm_q   <= simm_d;
        end
    end

    logic restart;
    // A branch in D with no valid instruction behind it has lost its delay slot.
    assign restart = valid_q & has_ds_q & ~dec.i_valid & ~dec.flush_D;

    assign dec.d_valid          = valid_q;
    assign dec.d_instr          = instr_q;
    assign dec.d_pc             = pc_q;
    assign dec.d_npc            = npc_q;
    assign dec.d_opcode         = instr_q[31:26];
    assign dec.d_fn             = instr_q[5:0];
    assign dec.d_rd             = instr_q[15:11];
    assign dec.d_sa             = instr_q[10:6];
    assign dec.d_rs             = rs_q;
    assign dec.d_rt             = rt_q;
    assign dec.d_wbr            = wbr_q;
    assign dec.d_target         = target_q;
    assign dec.d_has_delay_slot = has_ds_q;
    assign dec.d_op1_val        = op1_q;
    assign dec.d_op2_val        = op2_q;
    assign dec.d_rt_val         = rt_val_q;
    assign dec.d_simm           = simm_q;
    assign dec.d_restart        = restart;
    assign dec.d_restart_pc     = pc_q;
    assign dec.d_flush_X        = restart;

    // m_pc is carried for debug visibility only.
    logic unused_m_pc;
    assign unused_m_pc = ^dec.m_pc;

`ifdef YARI_DECODE_PERF_EN
    logic [31:0] bubble_d, bubble_q;
    logic [47:0] retired_d, retired_q;

    // Counter next-state; both wrap on overflow.
    always_comb begin
        bubble_d  = bubble_q;
        retired_d = retired_q;
        if (restart) bubble_d = bubble_q + 32'd1;
        if (dec.m_valid) retired_d = retired_q + 48'd1;
    end

    // Counter registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            bubble_q  <= '0;
            retired_q <= '0;
        end else begin
            bubble_q  <= bubble_d;
            retired_q <= retired_d;
        end
    end

    assign dec.perf_delay_slot_bubble = bubble_q;
    assign dec.perf_retired_inst      = retired_q;
`else
    assign dec.perf_delay_slot_bubble = 32'h0;
    assign dec.perf_retired_inst      = 48'h0;
`endif
endmodule

// File: tb/tb_yari_stage_decode.sv
// Scoreboard bench for yari_stage_decode: the driver pushes reference-model results,
// a negedge monitor pops and compares whenever D holds a valid instruction.
module tb_yari_stage_decode;
    localparam logic [31:0] ResetPc = 32'hBFC00000;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    yari_stage_decode_if dif ();

    yari_stage_decode #(.RESET_PC(ResetPc)) dut (
        .clock(clock),
        .rst  (rst),
        .dec  (dif.slave)
    );

    typedef struct {
        logic [31:0] instr, pc, npc, target, op1, op2, rtv, simm;
        logic [5:0]  opcode, fn, rs, rt, wbr;
        logic [4:0]  rd, sa;
        logic        ds;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] rf_model [64];
    int          checks = 0;
    int          failures = 0;
    logic        mon_en = 1'b0;
    logic        prev_iv = 1'b0;
    logic        mon_have, mon_restart;
    longint      exp_bubble = 0;
    longint      exp_retired = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Operand read as the pipeline sees it: newest producer wins, r0 is always zero.
    function automatic logic [31:0] read_model(input logic [5:0] r, input logic xv,
                                               input logic [5:0] xw, input logic [31:0] xr,
                                               input logic mv, input logic [5:0] mw,
                                               input logic [31:0] mr);
        if (r == 6'd0) return 32'h0;
        if (xv && xw == r) return xr;
        if (mv && mw == r) return mr;
        return rf_model[r];
    endfunction

    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic xv, input logic [5:0] xw,
                                       input logic [31:0] xr, input logic mv,
                                       input logic [5:0] mw, input logic [31:0] mr);
        exp_t e;
        logic [5:0] op = ins[31:26];
        logic [4:0] rs = ins[25:21];
        logic [4:0] rt = ins[20:16];
        logic [4:0] rd = ins[15:11];
        logic [5:0] fn = ins[5:0];
        logic [31:0] npc = pc + 32'd4;
        logic is_load  = op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
        logic is_alui  = op inside {[6'h08:6'h0f]};
        logic is_link  = (op == 6'h03) || (op == 6'h01 && rt inside {5'h10, 5'h11});
        logic is_ctl   = (op inside {[6'h02:6'h07]}) || (op == 6'h00 && fn inside {6'h08, 6'h09})
                         || (op == 6'h01 && rt inside {5'h00, 5'h01, 5'h10, 5'h11});
        logic is_mfc0  = (op == 6'h10) && (rs == 5'h00);
        logic is_mtc0  = (op == 6'h10) && (rs == 5'h04);
        logic has_imm  = !(op inside {6'h00, 6'h02, 6'h03, 6'h10, 6'h11, 6'h12, 6'h13});
        e.instr  = ins;
        e.pc     = pc;
        e.npc    = npc;
        e.opcode = op;
        e.fn     = fn;
        e.rd     = rd;
        e.sa     = ins[10:6];
        e.rs     = is_mfc0 ? 6'd32 + 6'(rd) : 6'(rs);
        e.rt     = 6'(rt);
        e.ds     = is_ctl;
        if (is_link)                    e.wbr = 6'd31;
        else if (op == 6'h00)           e.wbr = (fn == 6'h08) ? 6'd0 : 6'(rd);
        else if (is_alui || is_load)    e.wbr = 6'(rt);
        else if (is_mfc0)               e.wbr = 6'(rt);
        else if (is_mtc0)               e.wbr = 6'd32 + 6'(rd);
        else                            e.wbr = 6'd0;
        e.simm = 32'($signed(ins[15:0]));
        e.op1  = read_model(e.rs, xv, xw, xr, mv, mw, mr);
        e.rtv  = read_model(e.rt, xv, xw, xr, mv, mw, mr);
        if (op inside {6'h0c, 6'h0d, 6'h0e}) e.op2 = 32'(ins[15:0]);
        else if (op == 6'h0f)               e.op2 = 32'(ins[15:0]) * 32'h10000;
        else if (has_imm)                   e.op2 = e.simm;
        else                                e.op2 = e.rtv;
        if (op == 6'h02 || op == 6'h03)
            e.target = (npc & 32'hF000_0000) | (32'(ins[25:0]) << 2);
        else
            e.target = npc + (e.simm << 2);
        return e;
    endfunction

    // One pipeline cycle of stimulus; the expected D contents go into the scoreboard.
    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic xv, input logic [5:0] xw, input logic [31:0] xr,
                         input logic mv, input logic [5:0] mw, input logic [31:0] mr,
                         input logic fl);
        @(posedge clock);
        #1;
        dif.i_valid = iv;
        dif.i_instr = ins;
        dif.i_pc    = pc;
        dif.i_npc   = pc + 32'd4;
        dif.x_valid = xv;
        dif.x_wbr   = xw;
        dif.x_res   = xr;
        dif.m_valid = mv;
        dif.m_pc    = $urandom;
        dif.m_wbr   = mw;
        dif.m_res   = mr;
        dif.flush_D = fl;
        if (iv) q.push_back(ref_model(ins, pc, xv, xw, xr, mv, mw, mr));
        if (mv && mw != 6'd0) rf_model[mw] = mr;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
    endtask

    function automatic logic [5:0] pick_reg();
        int k = $urandom_range(0, 9);
        if (k < 8) return 6'(k);
        return 6'd32 + 6'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rs = 5'($urandom_range(0, 7));
        logic [4:0]  rt = 5'($urandom_range(0, 7));
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [15:0] imm = 16'($urandom);
        logic [5:0]  fns [8] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h08, 6'h09};
        logic [5:0]  lds [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
        logic [5:0]  sts [5] = '{6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e};
        logic [4:0]  ris [4] = '{5'h00, 5'h01, 5'h10, 5'h11};
        case ($urandom_range(0, 10))
            0: return {6'h00, rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 7)]};
            1: return {6'($urandom_range(8, 15)), rs, rt, imm};
            2: return {lds[$urandom_range(0, 6)], rs, rt, imm};
            3: return {sts[$urandom_range(0, 4)], rs, rt, imm};
            4: return {6'($urandom_range(4, 7)), rs, rt, imm};
            5: return {6'h01, rs, ris[$urandom_range(0, 3)], imm};
            6: return {6'h02, 26'($urandom)};
            7: return {6'h03, 26'($urandom)};
            8: return {6'h10, 5'h00, rt, 5'($urandom_range(0, 3)), 11'h0};
            9: return {6'h10, 5'h04, rt, 5'($urandom_range(0, 3)), 11'h0};
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares D against the scoreboard and tracks restart/counter expectations.
    always @(negedge clock) begin
        if (mon_en) begin
            mon_have = 1'b0;
            chk("d_valid", 64'(dif.d_valid), 64'(prev_iv));
            if (prev_iv && q.size() > 0) begin
                mon_e = q.pop_front();
                mon_have = 1'b1;
                chk("d_instr", 64'(dif.d_instr), 64'(mon_e.instr));
                chk("d_pc", 64'(dif.d_pc), 64'(mon_e.pc));
                chk("d_npc", 64'(dif.d_npc), 64'(mon_e.npc));
                chk("d_opcode", 64'(dif.d_opcode), 64'(mon_e.opcode));
                chk("d_fn", 64'(dif.d_fn), 64'(mon_e.fn));
                chk("d_rd", 64'(dif.d_rd), 64'(mon_e.rd));
                chk("d_sa", 64'(dif.d_sa), 64'(mon_e.sa));
                chk("d_rs", 64'(dif.d_rs), 64'(mon_e.rs));
                chk("d_rt", 64'(dif.d_rt), 64'(mon_e.rt));
                chk("d_wbr", 64'(dif.d_wbr), 64'(mon_e.wbr));
                chk("d_target", 64'(dif.d_target), 64'(mon_e.target));
                chk("d_has_delay_slot", 64'(dif.d_has_delay_slot), 64'(mon_e.ds));
                chk("d_op1_val", 64'(dif.d_op1_val), 64'(mon_e.op1));
                chk("d_op2_val", 64'(dif.d_op2_val), 64'(mon_e.op2));
                chk("d_rt_val", 64'(dif.d_rt_val), 64'(mon_e.rtv));
                chk("d_simm", 64'(dif.d_simm), 64'(mon_e.simm));
                chk("d_restart_pc", 64'(dif.d_restart_pc), 64'(mon_e.pc));
            end
            mon_restart = mon_have && mon_e.ds && !dif.i_valid && !dif.flush_D;
            chk("d_restart", 64'(dif.d_restart), 64'(mon_restart));
            chk("d_flush_X", 64'(dif.d_flush_X), 64'(mon_restart));
`ifdef YARI_DECODE_PERF_EN
            chk("perf_bubble", 64'(dif.perf_delay_slot_bubble), 64'(exp_bubble[31:0]));
            chk("perf_retired", 64'(dif.perf_retired_inst), 64'(exp_retired[47:0]));
`else
            chk("perf_bubble", 64'(dif.perf_delay_slot_bubble), 64'(0));
            chk("perf_retired", 64'(dif.perf_retired_inst), 64'(0));
`endif
            if (mon_restart) exp_bubble++;
            if (dif.m_valid) exp_retired++;
            prev_iv = dif.i_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dif.i_valid = 0; dif.i_instr = 0; dif.i_pc = 0; dif.i_npc = 0;
        dif.x_valid = 0; dif.x_wbr = 0; dif.x_res = 0;
        dif.m_valid = 0; dif.m_pc = 0; dif.m_wbr = 0; dif.m_res = 0; dif.flush_D = 0;
        rf_model[0] = 32'h0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_d_valid", 64'(dif.d_valid), 64'(0));
        chk("rst_d_instr", 64'(dif.d_instr), 64'(0));
        chk("rst_d_pc", 64'(dif.d_pc), 64'(ResetPc));
        chk("rst_d_npc", 64'(dif.d_npc), 64'(ResetPc));
        chk("rst_d_wbr", 64'(dif.d_wbr), 64'(0));
        chk("rst_d_op1", 64'(dif.d_op1_val), 64'(0));
        chk("rst_d_target", 64'(dif.d_target), 64'(0));
        chk("rst_d_restart", 64'(dif.d_restart), 64'(0));
        chk("rst_bubble", 64'(dif.perf_delay_slot_bubble), 64'(0));
        chk("rst_retired", 64'(dif.perf_retired_inst), 64'(0));
        rst = 1'b1;
        mon_en = 1'b1;

        // Ten retirements targeting r0, while D decodes OR r6,r0,r0 (must read zero).
        for (int i = 0; i < 10; i++)
            drive(1'b1, 32'h0000_3025, 32'h1000 + 32'(i * 4), 1'b0, 6'd0, 32'h0,
                  1'b1, 6'd0, $urandom, 1'b0);
        idle();
        @(negedge clock);
`ifdef YARI_DECODE_PERF_EN
        chk("retired_after_10", 64'(dif.perf_retired_inst), 64'(10));
`else
        chk("retired_after_10", 64'(dif.perf_retired_inst), 64'(0));
`endif

        // Give every register a known value.
        for (int r = 1; r < 64; r++)
            drive(1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'(r), $urandom, 1'b0);

        // Directed cases.
        drive(1'b1, 32'h2402FFFF, 32'h200, 0, 6'd0, 0, 0, 6'd0, 0, 0);              // ADDIU
        drive(1'b1, 32'h00632021, 32'h204, 0, 6'd0, 0, 1, 6'd3, 32'h1234, 0);       // ADDU M bypass
        drive(1'b1, 32'h00632021, 32'h208, 1, 6'd3, 32'h5678, 1, 6'd3, 32'h1234, 0); // X wins
        drive(1'b1, 32'h10220004, 32'h100, 0, 6'd0, 0, 0, 6'd0, 0, 0);              // BEQ
        drive(1'b0, 32'h0, 32'h0, 0, 6'd0, 0, 0, 6'd0, 0, 0);                        // lost slot
        drive(1'b1, 32'h10220004, 32'h100, 0, 6'd0, 0, 0, 6'd0, 0, 0);              // BEQ again
        drive(1'b0, 32'h0, 32'h0, 0, 6'd0, 0, 0, 6'd0, 0, 1);                        // flushed
        drive(1'b1, 32'h0C000100, 32'h80000000, 0, 6'd0, 0, 0, 6'd0, 0, 0);         // JAL
        drive(1'b1, 32'h34058000, 32'h300, 0, 6'd0, 0, 0, 6'd0, 0, 0);              // ORI
        drive(1'b1, 32'h3C051234, 32'h304, 0, 6'd0, 0, 0, 6'd0, 0, 0);              // LUI
        idle();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            drive(($urandom_range(0, 3) != 0), gen_instr(), pc,
                  1'($urandom_range(0, 1)), pick_reg(), $urandom,
                  1'($urandom_range(0, 1)), pick_reg(), $urandom,
                  ($urandom_range(0, 4) == 0));
        end
        repeat (3) idle();
        @(negedge clock);
        chk("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/yari_stage_decode.md
Name: yari_stage_decode

Overview:
- Decode (D) stage of the five-stage YARI MIPS-I pipeline (I, D, X, M, W).
- Latches the fetched instruction and decodes its fields.
- Reads a 64-entry register file, which the M stage writes, with X/M bypass.
- Produces register-aligned operands for X, plus a delay-slot-bubble restart request and performance counters.

Parameters:
- RESET_PC, 32'hBFC00000, value of d_pc/d_npc after reset.

Ports:
- clock  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- i_valid  in  1  fetched instruction valid (already gated by flush_I)
- i_instr  in  32  fetched instruction
- i_pc  in  32  its PC
- i_npc  in  32  its PC+4
- x_valid  in  1  X result valid (already gated by flush_X)
- x_wbr  in  6  X destination register, 0 = none
- x_res  in  32  X result
- m_valid  in  1  M result valid
- m_pc  in  32  M PC (debug only, unused by logic)
- m_wbr  in  6  M destination register, 0 = none
- m_res  in  32  M result; written to the register file
- flush_D  in  1  kills the instruction currently held in D
- d_valid, d_instr[32], d_pc[32], d_npc[32]  out  latched from i_*
- d_opcode[6], d_fn[6], d_rd[5], d_sa[5]  out  instruction fields
- d_rs[6], d_rt[6]  out  source specifiers
- d_wbr[6]  out  destination specifier
- d_target[32]  out  branch/jump target
- d_has_delay_slot  out  1  instruction is a branch or jump
- d_op1_val, d_op2_val, d_rt_val, d_simm  out  32  operands
- d_restart  out  1  restart request
- d_restart_pc  out  32  restart PC
- d_flush_X  out  1  flush request for X
- perf_delay_slot_bubble  out  32  delay-slot bubble count
- perf_retired_inst  out  48  retired instruction count

Behaviour:
- Timing: no stall. Every posedge, D latches the i_* inputs and the decoded/operand values computed combinationally from i_instr.
- Outputs are valid one cycle after the I inputs.
- Reset (rst=0, async): d_valid=0, d_instr=0, d_pc=d_npc=RESET_PC, all decoded fields/operands=0, counters=0. The register file contents are not reset.
- Register numbering: 6-bit. Indices 0..31 are GPRs; 32..63 are CP0 registers. Index 0 always reads 0 and is never written.
- Source specifiers: d_rs={0,rs} and d_rt={0,rt}, except MFC0, where d_rs={1,rd}.
- d_wbr:
  - R-type: rd
  - JALR: rd
  - I-type ALU and loads: rt
  - JAL, BLTZAL, BGEZAL: 31
  - MTC0: {1,rd}
  - stores, branches, J: 0
  - any computed 0 stays 0
- Operand read, priority high to low:
  1. x_valid and x_wbr==src and src!=0 -> x_res
  2. m_valid and m_wbr==src and src!=0 -> m_res
  3. register file value
- d_op1_val = read(rs specifier).
- d_rt_val = read(rt specifier).
- d_op2_val:
  - zero-extended imm16 for ANDI/ORI/XORI
  - {imm16,16'h0} for LUI
  - sign-extended imm16 for other I-type
  - shamt is carried separately in d_sa
  - otherwise d_rt_val
- d_simm: sign-extended imm16.
- d_target:
  - J/JAL: {i_npc[31:28], instr[25:0], 2'b00}
  - otherwise: i_npc + (simm<<2), 32-bit wrap
- Register file write: at posedge when m_valid and m_wbr!=0, regfile[m_wbr] <= m_res. Same-cycle read of that register returns m_res via the bypass.
- Delay-slot bubble: d_restart = d_valid & d_has_delay_slot & ~i_valid & ~flush_D (combinational).
  - When d_restart is asserted: d_restart_pc=d_pc, d_flush_X=1.
  - Otherwise d_restart_pc=d_pc and d_flush_X=0.
- Counters:
  - perf_delay_slot_bubble increments on each cycle d_restart=1.
  - perf_retired_inst increments each cycle m_valid=1.
  - Both wrap.

Optional Feature:
- Macro YARI_DECODE_PERF_EN.
- When defined: both counters exist as specified.
- When undefined: no counter registers; perf_delay_slot_bubble and perf_retired_inst are tied to 0.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package: opcode, funct and REGIMM constants; CP0 bank offset (32); register-index width (6).
- One natural sub-module: yari_regfile, 64x32, two combinational read ports, one write port, r0 hardwired to zero, no reset.

Test Plan:
- Reset then release: d_valid=0, d_pc=32'hBFC00000, perf counters=0.
- ADDIU r2,r0,-1 (0x2402FFFF) -> next cycle d_wbr=2, d_simm=32'hFFFFFFFF, d_op2_val=32'hFFFFFFFF, d_op1_val=0.
- M writes r3=0x1234 while D decodes ADDU r4,r3,r3 -> d_op1_val=d_op2_val=0x1234. Next, x_wbr=3/x_res=0x5678 plus m_wbr=3/m_res=0x1234 -> X wins: 0x5678.
- BEQ at pc 0x100 with offset 4 -> d_target=0x114, d_has_delay_slot=1. Following cycle i_valid=0 -> d_restart=1, d_restart_pc=0x100, d_flush_X=1, bubble counter +1. Repeat with flush_D=1 -> no restart.
- JAL at pc 0x80000000, index 0x100 -> d_target=0x80000400, d_wbr=31. ORI r5,r0,0x8000 -> d_op2_val=0x00008000. LUI r5,0x1234 -> d_op2_val=0x12340000.
- m_valid=1 for 10 cycles with m_wbr=0 -> perf_retired_inst=10; register file unchanged, r0 reads 0.
